vga_fb_ctrl: RTL and testbench
==============================

# vga_fb_ctrl

Parametrised VGA display controller: a generalised successor to the fixed-mode `vga` timing core. It generates HSYNC/VSYNC for any mode set by parameters and scans out a 2-bit-per-pixel framebuffer through a 4-entry, 12-bit palette. The framebuffer can be downscaled by a power of two, with pixel replication on output. It sits directly under the board top level. The write port is driven by user logic; the sync and RGB outputs go to the VGA connector.

## Interface
- `HD`, 1280: visible pixels per line
- `HFP`, 48 / `HSW`, 112 / `HBP`, 248: horizontal front porch, sync width and back porch, in pixels
- `VD`, 1024: visible lines
- `VFP`, 1 / `VSW`, 3 / `VBP`, 38: vertical front porch, sync width and back porch, in lines
- `HSYNC_BITS`, 11 / `VSYNC_BITS`, 11: widths of the horizontal and vertical counters
- `HS_POL`, 1 / `VS_POL`, 1: active level of each sync signal
- `SCALE_SHIFT`, 2: framebuffer size is (HD>>SCALE_SHIFT) x (VD>>SCALE_SHIFT); each stored pixel is shown as a 2^SCALE_SHIFT square

Ports:
- `clk_i`  in  1  pixel clock
- `rst_i`  in  1  synchronous reset, active-high
- `addr_x_i`  in  11  framebuffer write column, in scaled coordinates
- `addr_y_i`  in  11  framebuffer write row, in scaled coordinates
- `color_i`  in  2  palette index to write
- `we_i`  in  1  framebuffer write strobe
- `pal_we_i`  in  1  palette write strobe (used only with the macro)
- `pal_idx_i`  in  2  palette entry to write
- `pal_rgb_i`  in  12  palette value to write, {R[3:0],G[3:0],B[3:0]}
- `VGA_HS_o`  out  1  horizontal sync
- `VGA_VS_o`  out  1  vertical sync
- `RGB_o`  out  12  pixel colour
- `LED_o`  out  12  frame counter, modulo 4096
- `frame_start_o`  out  1  one-cycle pulse on the first visible pixel of a frame

## Operation
- Counters:
  - `h_cnt` counts 0..HTOT-1, where HTOT = HD+HFP+HSW+HBP.
  - `v_cnt` advances when `h_cnt` wraps and counts 0..VTOT-1, where VTOT = VD+VFP+VSW+VBP.
  - Both wrap to 0.
- Regions:
  - Visible when h_cnt<HD and v_cnt<VD.
  - HS is active for HD+HFP <= h_cnt < HD+HFP+HSW.
  - VS is active for VD+VFP <= v_cnt < VD+VFP+VSW.
- Framebuffer:
  - Single-clock dual-port RAM of 2-bit words; inferred block RAM with a synchronous read.
  - Read address = (v_cnt>>S)*(HD>>S) + (h_cnt>>S).
  - Write address is formed the same way from `addr_y_i` and `addr_x_i`.
  - A write with addr_x_i >= HD>>S or addr_y_i >= VD>>S is dropped; no alias or wrap into other pixels.
  - A read and a write to the same address in the same cycle: the read returns the old data.
  - Contents are not cleared by reset.
- Palette:
  - 4 x 12-bit registers. Reset values: idx0=12'h000, idx1=12'hF00, idx2=12'h0F0, idx3=12'hFFF.
  - `RGB_o` = palette[pixel] in the visible region, otherwise 12'h000.
- LED_o increments on every frame_start pulse and wraps 4095 -> 0.
- Reset values:
  - h_cnt=v_cnt=0.
  - VGA_HS_o = !HS_POL and VGA_VS_o = !VS_POL.
  - RGB_o=0, LED_o=0, frame_start_o=0.
  - All pipeline valid flags are cleared.
- Reset mid-frame: counters return to 0 on the next edge and outputs show reset values the cycle after. The first frame_start pulse comes 2 cycles after rst_i deasserts.

## Timing
- Pipeline, 2 stages; sync signals are delayed to stay aligned with RGB:
  - Stage 0: counters and region decode.
  - Stage 1: RAM read, with the region flags registered.
  - Stage 2: palette lookup, then registered outputs.
- Latency from counters (h_cnt,v_cnt) to RGB_o/HS/VS/frame_start_o is exactly 2 clocks. All outputs are registered.
- A framebuffer write is visible to any scanout read issued 1 or more cycles after the write edge.
- A palette write takes effect on RGB_o from the second edge after it.
- we_i and pal_we_i in the same cycle are independent; both complete.

## Configuration
- `VGA_FB_PALETTE_WR_EN`:
  - Defined: the palette registers are writable via pal_we_i/pal_idx_i/pal_rgb_i.
  - Undefined: the palette is constant at its reset values, pal_* inputs are ignored, and no palette flops are synthesised.

## Test plan
- Reset, then run 2 frames (HD=8, HFP=2, HSW=2, HBP=2, VD=4, VFP=1, VSW=1, VBP=1, S=0) -> HS active for 2 cycles each 14-cycle line, VS active for exactly 1 line of the 7-line frame, frame_start every 98 cycles, LED_o = 2.
- Write color=1 at (3,2); scan that pixel -> RGB_o=12'hF00 exactly 2 cycles after h_cnt=3,v_cnt=2; neighbouring pixels give 12'h000.
- Write at (8,0) with HD>>S=8 -> dropped; pixel (0,1) unchanged.
- S=1, write color=3 at (1,1) -> a 2x2 block at screen (2..3,2..3) is 12'hFFF.
- With VGA_FB_PALETTE_WR_EN defined: set idx1=12'h123 -> next shown idx1 pixel is 12'h123. Without the macro: the same write leaves it at 12'hF00.
- Assert rst_i for 1 cycle mid-line -> outputs show reset values, the count restarts at 0, and frame_start comes 2 cycles after release.

Source files
------------

// File: rtl/vga_fb_ctrl.sv
// Parametrised VGA timing generator with a 2-bpp framebuffer scanned out through a 4-entry palette.
// Define VGA_FB_PALETTE_WR_EN to make the palette writable; otherwise it is fixed at its reset colours.
module vga_fb_ctrl #(
  parameter int HD          = 1280,
  parameter int HFP         = 48,
  parameter int HSW         = 112,
  parameter int HBP         = 248,
  parameter int VD          = 1024,
  parameter int VFP         = 1,
  parameter int VSW         = 3,
  parameter int VBP         = 38,
  parameter int HSYNC_BITS  = 11,
  parameter int VSYNC_BITS  = 11,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] addr_x_i,
  input  logic [10:0] addr_y_i,
  input  logic [1:0]  color_i,
  input  logic        we_i,
  input  logic        pal_we_i,
  input  logic [1:0]  pal_idx_i,
  input  logic [11:0] pal_rgb_i,
  output logic        VGA_HS_o,
  output logic        VGA_VS_o,
  output logic [11:0] RGB_o,
  output logic [11:0] LED_o,
  output logic        frame_start_o
);

  localparam int HTOT     = HD + HFP + HSW + HBP;
  localparam int VTOT     = VD + VFP + VSW + VBP;
  localparam int FB_W     = HD >> SCALE_SHIFT;
  localparam int FB_H     = VD >> SCALE_SHIFT;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  function automatic logic [11:0] pal_init(input logic [1:0] idx);
    case (idx)
      2'd0:    pal_init = 12'h000;
      2'd1:    pal_init = 12'hF00;
      2'd2:    pal_init = 12'h0F0;
      default: pal_init = 12'hFFF;
    endcase
  endfunction

  // ---- Stage 0: raster counters and region decode ----
  logic [HSYNC_BITS-1:0] h_cnt;
  logic [VSYNC_BITS-1:0] v_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HSYNC_BITS'(HTOT - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VSYNC_BITS'(VTOT - 1)) ? '0 : v_cnt + VSYNC_BITS'(1);
    end else begin
      h_cnt <= h_cnt + HSYNC_BITS'(1);
    end
  end

  logic          vis_p0, hs_p0, vs_p0, fs_p0;
  logic [AW-1:0] rd_addr_p0;

  always_comb begin
    vis_p0 = (32'(h_cnt) < HD) && (32'(v_cnt) < VD);
    hs_p0  = (32'(h_cnt) >= HD + HFP) && (32'(h_cnt) < HD + HFP + HSW);
    vs_p0  = (32'(v_cnt) >= VD + VFP) && (32'(v_cnt) < VD + VFP + VSW);
    fs_p0  = (h_cnt == '0) && (v_cnt == '0);
    // Blanking addresses are forced to 0 so the RAM index never leaves its range.
    rd_addr_p0 = '0;
    if (vis_p0)
      rd_addr_p0 = AW'((32'(v_cnt) >> SCALE_SHIFT) * FB_W + (32'(h_cnt) >> SCALE_SHIFT));
  end

  logic          wr_ok;
  logic [AW-1:0] wr_addr;

  always_comb begin
    wr_ok   = we_i && (32'(addr_x_i) < FB_W) && (32'(addr_y_i) < FB_H);
    wr_addr = '0;
    if (wr_ok)
      wr_addr = AW'(32'(addr_y_i) * FB_W + 32'(addr_x_i));
  end

  // ---- Stage 1: framebuffer read, region flags registered ----
  logic [1:0] fb_mem [FB_DEPTH];
  logic [1:0] rd_data_p1;

  // Read-before-write: a same-address read in the write cycle returns the old word.
  always_ff @(posedge clk_i) begin
    if (wr_ok)
      fb_mem[wr_addr] <= color_i;
    rd_data_p1 <= fb_mem[rd_addr_p0];
  end

  logic vld_p1, vis_p1, hs_p1, vs_p1, fs_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vis_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      fs_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b1;
      vis_p1 <= vis_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      fs_p1  <= fs_p0;
    end
  end

  logic [11:0] pix_rgb_p1;

`ifdef VGA_FB_PALETTE_WR_EN
  logic [11:0] pal_q [4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++)
        pal_q[i] <= pal_init(2'(i));
    end else if (pal_we_i) begin
      pal_q[pal_idx_i] <= pal_rgb_i;
    end
  end

  assign pix_rgb_p1 = pal_q[rd_data_p1];
`else
  logic unused_pal;
  assign unused_pal = ^{pal_we_i, pal_idx_i, pal_rgb_i};
  assign pix_rgb_p1 = pal_init(rd_data_p1);
`endif

  // ---- Stage 2: palette lookup result and delayed syncs registered to the pins ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RGB_o         <= 12'h000;
      VGA_HS_o      <= ~HS_ACT;
      VGA_VS_o      <= ~VS_ACT;
      frame_start_o <= 1'b0;
      LED_o         <= 12'h000;
    end else begin
      RGB_o         <= (vld_p1 && vis_p1) ? pix_rgb_p1 : 12'h000;
      VGA_HS_o      <= (vld_p1 && hs_p1) ? HS_ACT : ~HS_ACT;
      VGA_VS_o      <= (vld_p1 && vs_p1) ? VS_ACT : ~VS_ACT;
      frame_start_o <= vld_p1 && fs_p1;
      if (vld_p1 && fs_p1)
        LED_o <= LED_o + 12'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Self-checking bench for vga_fb_ctrl: two small-mode instances (scale 1 and scale 2, opposite sync
// polarities) against a frame-level reference model, plus directed boundary checks.
module tb_vga_fb_ctrl;

  localparam int HTOT  = 14;
  localparam int VTOT  = 7;
  localparam int FRAME = HTOT * VTOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ax = '0, ay = '0;
  logic [1:0]  color = '0, pal_idx = '0;
  logic        we = 1'b0, pal_we = 1'b0;
  logic [11:0] pal_rgb = '0;

  logic        hs0, vs0, fs0, hs1, vs1, fs1;
  logic [11:0] rgb0, led0, rgb1, led1;

  always #5 clk = ~clk;

  vga_fb_ctrl #(.HD(8), .HFP(2), .HSW(2), .HBP(2), .VD(4), .VFP(1), .VSW(1), .VBP(1),
                .HSYNC_BITS(4), .VSYNC_BITS(3), .HS_POL(1), .VS_POL(1), .SCALE_SHIFT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_x_i(ax), .addr_y_i(ay), .color_i(color), .we_i(we),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
    .VGA_HS_o(hs0), .VGA_VS_o(vs0), .RGB_o(rgb0), .LED_o(led0), .frame_start_o(fs0));

  vga_fb_ctrl #(.HD(8), .HFP(2), .HSW(2), .HBP(2), .VD(4), .VFP(1), .VSW(1), .VBP(1),
                .HSYNC_BITS(4), .VSYNC_BITS(3), .HS_POL(0), .VS_POL(0), .SCALE_SHIFT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_x_i(ax), .addr_y_i(ay), .color_i(color), .we_i(we),
    .pal_we_i(pal_we), .pal_idx_i(pal_idx), .pal_rgb_i(pal_rgb),
    .VGA_HS_o(hs1), .VGA_VS_o(vs1), .RGB_o(rgb1), .LED_o(led1), .frame_start_o(fs1));

  typedef struct {
    bit       vis;
    bit [1:0] pix;
    bit       hs;
    bit       vs;
    bit       fs;
  } exp_t;

  localparam exp_t IDLE = '{vis: 1'b0, pix: 2'd0, hs: 1'b0, vs: 1'b0, fs: 1'b0};

  exp_t        q0[$], q1[$];
  bit [1:0]    fb0 [4][8];
  bit [1:0]    fb1 [2][4];
  logic [11:0] pal_m [4];
  logic [11:0] pal_prev [4];
  int          k = 0;
  int          led_m0 = 0, led_m1 = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic exp_t model_at(input int cnt, input int sh);
    exp_t e;
    int h, v;
    h = cnt % HTOT;
    v = cnt / HTOT;
    e.vis = (h < 8) && (v < 4);
    e.pix = 2'd0;
    if (e.vis) e.pix = (sh == 0) ? fb0[v][h] : fb1[v >> 1][h >> 1];
    e.hs = (h >= 10) && (h < 12);
    e.vs = (v == 5);
    e.fs = (cnt == 0);
    return e;
  endfunction

  task automatic reset_palette();
    pal_m[0] = 12'h000; pal_m[1] = 12'hF00; pal_m[2] = 12'h0F0; pal_m[3] = 12'hFFF;
    pal_prev = pal_m;
  endtask

  // One clock: apply this edge's inputs to the model, predict, then compare both instances.
  task automatic step();
    exp_t e0, e1;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      q0.delete(); q1.delete();
      q0.push_back(IDLE); q0.push_back(IDLE);
      q1.push_back(IDLE); q1.push_back(IDLE);
      led_m0 = 0; led_m1 = 0;
      reset_palette();
    end else begin
      k++;
      if (we && ax < 8 && ay < 4) fb0[ay][ax] = color;
      if (we && ax < 4 && ay < 2) fb1[ay][ax] = color;
      pal_prev = pal_m;
`ifdef VGA_FB_PALETTE_WR_EN
      if (pal_we) pal_m[pal_idx] = pal_rgb;
`endif
    end
    q0.push_back(model_at(k % FRAME, 0));
    q1.push_back(model_at(k % FRAME, 1));
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    if (e0.fs) led_m0++;
    if (e1.fs) led_m1++;
    chk("rgb0", rgb0, e0.vis ? pal_prev[e0.pix] : 12'h000);
    chk("hs0", 12'(hs0), 12'(e0.hs));
    chk("vs0", 12'(vs0), 12'(e0.vs));
    chk("fs0", 12'(fs0), 12'(e0.fs));
    chk("led0", led0, 12'(led_m0));
    chk("rgb1", rgb1, e1.vis ? pal_prev[e1.pix] : 12'h000);
    chk("hs1", 12'(hs1), 12'(!e1.hs));
    chk("vs1", 12'(vs1), 12'(!e1.vs));
    chk("fs1", 12'(fs1), 12'(e1.fs));
    chk("led1", led1, 12'(led_m1));
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  int          tgt;
  logic [11:0] idx1_exp;

  initial begin
    reset_palette();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Clear the whole framebuffer so later expectations do not depend on power-up contents.
    for (int i = 0; i < 32; i++) begin
      ax = 11'(i % 8); ay = 11'(i / 8); color = 2'd0; we = 1'b1;
      step();
    end
    ax = 11'd3; ay = 11'd2; color = 2'd1; step();
    ax = 11'd1; ay = 11'd1; color = 2'd3; step();
    ax = 11'd8; ay = 11'd0; color = 2'd3; step();
    we = 1'b0;

    // Second frame: pixel outputs appear 2 cycles after counter value k-2.
    run_to(FRAME + 16); chk("oob_no_alias_0_1", rgb0, 12'h000);
    run_to(FRAME + 32); chk("left_of_3_2", rgb0, 12'h000);
                        chk("s1_blk_2_2", rgb1, 12'hFFF);
    run_to(FRAME + 33); chk("pix_3_2", rgb0, 12'hF00);
                        chk("s1_blk_3_2", rgb1, 12'hFFF);
    run_to(FRAME + 34); chk("right_of_3_2", rgb0, 12'h000);
    run_to(FRAME + 46); chk("s1_blk_2_3", rgb1, 12'hFFF);
    run_to(FRAME + 47); chk("s1_blk_3_3", rgb1, 12'hFFF);
    run_to(2 * FRAME);  chk("led_two_frames0", led0, 12'd2);
                        chk("led_two_frames1", led1, 12'd2);

    pal_we = 1'b1; pal_idx = 2'd1; pal_rgb = 12'h123;
    step();
    pal_we = 1'b0;
`ifdef VGA_FB_PALETTE_WR_EN
    idx1_exp = 12'h123;
`else
    idx1_exp = 12'hF00;
`endif
    run_to(2 * FRAME + 33); chk("pal_idx1_write", rgb0, idx1_exp);

    repeat (400) begin
      we      = 1'($urandom_range(0, 1));
      ax      = 11'($urandom_range(0, 9));
      ay      = 11'($urandom_range(0, 5));
      color   = 2'($urandom);
      pal_we  = ($urandom_range(0, 15) == 0);
      pal_idx = 2'($urandom);
      pal_rgb = 12'($urandom);
      step();
    end
    we = 1'b0; pal_we = 1'b0;

    // Single-cycle reset in the middle of a visible line.
    tgt = k + (HTOT - k % HTOT) + 5;
    run_to(tgt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_rgb", rgb0, 12'h000);
    chk("rst_led", led0, 12'h000);
    chk("rst_hs1", 12'(hs1), 12'd1);
    chk("rst_fs", 12'(fs0), 12'd0);
    step(); chk("fs_after_1", 12'(fs0), 12'd0);
    step(); chk("fs_after_2", 12'(fs0), 12'd1);
            chk("led_after_rst", led0, 12'd1);

    repeat (150) begin
      we    = 1'($urandom_range(0, 1));
      ax    = 11'($urandom_range(0, 9));
      ay    = 11'($urandom_range(0, 5));
      color = 2'($urandom);
      step();
    end
    we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
